// File: rtl/atm_session_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : atm_session_ctrl
// Purpose  : Multi-account ATM session controller. It handles one card
//            session at a time and holds a balance and a lock bit for each
//            account. It checks the PIN with retry lockout, runs withdraw,
//            deposit and transfer with range and overflow checks, and uses a
//            confirm/receipt handshake. An inactivity timer forces a card
//            eject.
// Ports    : clk            - rising-edge clock
//            reset          - asynchronous active-low reset
//            card_in        - card-insert strobe (IDLE only)
//            card_idx       - account selected on insert
//            pin_valid/pin  - PIN entry strobe and value
//            op_valid/opcode- opcode strobe (0 eject,1 bal,2 wd,3 dep,4 xfer)
//            amt_valid      - amount/destination strobe
//            amount/dest_idx- transaction amount and transfer destination
//            confirm_valid  - confirm strobe; confirm=1 proceed, 0 cancel
//            receipt_req    - receipt request, sampled with confirm_valid
//            state_o        - current state encoding
//            balance_o      - balance of the session account
//            done/receipt/card_eject/err_valid - one-cycle pulses
//            err            - last error code
//            locked         - session account is locked
// Revision : 1.0 - initial release
// ============================================================================
module atm_session_ctrl #(
  parameter int          PIN_W       = 14,
  parameter int          AMT_W       = 32,
  parameter int          NUM_ACCTS   = 4,
  parameter int          MAX_TRIES   = 3,
  parameter int          TIMEOUT_CYC = 1000,
  parameter int          PIN_VALUE   = 8030,
  parameter int unsigned INIT_BAL    = 100000,
  localparam int         IDX_W       = (NUM_ACCTS > 1) ? $clog2(NUM_ACCTS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             card_in,
  input  logic [IDX_W-1:0] card_idx,
  input  logic             pin_valid,
  input  logic [PIN_W-1:0] pin,
  input  logic             op_valid,
  input  logic [2:0]       opcode,
  input  logic             amt_valid,
  input  logic [AMT_W-1:0] amount,
  input  logic [IDX_W-1:0] dest_idx,
  input  logic             confirm_valid,
  input  logic             confirm,
  input  logic             receipt_req,
  output logic [3:0]       state_o,
  output logic [AMT_W-1:0] balance_o,
  output logic             done,
  output logic             receipt,
  output logic             card_eject,
  output logic             err_valid,
  output logic [3:0]       err,
  output logic             locked
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_PIN     = 4'd1,
    S_HOME    = 4'd2,
    S_BAL     = 4'd3,
    S_AMT     = 4'd4,
    S_CONFIRM = 4'd5,
    S_EXEC    = 4'd6,
    S_RECEIPT = 4'd7,
    S_EJECT   = 4'd8
  } state_t;

  localparam logic [2:0] c_op_eject    = 3'd0;
  localparam logic [2:0] c_op_balance  = 3'd1;
  localparam logic [2:0] c_op_withdraw = 3'd2;
  localparam logic [2:0] c_op_deposit  = 3'd3;
  localparam logic [2:0] c_op_transfer = 3'd4;

  localparam logic [3:0] c_err_none    = 4'd0;
  localparam logic [3:0] c_err_pin     = 4'd1;
  localparam logic [3:0] c_err_locked  = 4'd2;
  localparam logic [3:0] c_err_opcode  = 4'd3;
  localparam logic [3:0] c_err_funds   = 4'd4;
  localparam logic [3:0] c_err_zero    = 4'd5;
  localparam logic [3:0] c_err_idx     = 4'd6;
  localparam logic [3:0] c_err_ovf     = 4'd7;
  localparam logic [3:0] c_err_timeout = 4'd8;

  localparam int                c_try_w    = $clog2(MAX_TRIES + 1);
  localparam int                c_tmr_w    = $clog2(TIMEOUT_CYC);
  localparam logic [c_try_w-1:0] c_max_try = c_try_w'(MAX_TRIES);
  localparam logic [c_tmr_w-1:0] c_tmr_max = c_tmr_w'(TIMEOUT_CYC - 1);
  localparam logic [PIN_W-1:0]  c_pin      = PIN_W'(PIN_VALUE);
  localparam logic [AMT_W-1:0]  c_init_bal = AMT_W'(INIT_BAL);
  localparam logic [IDX_W:0]    c_num_acct = (IDX_W + 1)'(NUM_ACCTS);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t               state_q,   state_d;
  logic [IDX_W-1:0]     sess_q,    sess_d;
  logic [c_try_w-1:0]   tries_q,   tries_d;
  logic [c_tmr_w-1:0]   timer_q,   timer_d;
  logic [2:0]           op_q,      op_d;
  logic [AMT_W-1:0]     amt_q,     amt_d;
  logic [IDX_W-1:0]     dest_q,    dest_d;
  logic                 rcpt_q,    rcpt_d;
  logic [AMT_W-1:0]     bal_q [NUM_ACCTS];
  logic [AMT_W-1:0]     bal_d [NUM_ACCTS];
  logic [NUM_ACCTS-1:0] lock_q,    lock_d;
  logic [AMT_W-1:0]     balance_q, balance_d;
  logic                 done_q,    done_d;
  logic                 receipt_q, receipt_d;
  logic                 eject_q,   eject_d;
  logic                 errv_q,    errv_d;
  logic [3:0]           err_q,     err_d;
  logic                 locked_q,  locked_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic                 w_card_ok;
  logic                 w_dest_ok;
  logic [AMT_W-1:0]     w_sess_bal;
  logic [AMT_W-1:0]     w_dest_bal;
  logic [AMT_W:0]       w_dep_sum;
  logic [AMT_W:0]       w_xfer_sum;
  logic [c_try_w-1:0]   w_tries_inc;
  logic [AMT_W-1:0]     w_exec_bal;
  logic                 w_timed;
  logic                 w_timeout;
  logic                 w_consumed;

  assign w_card_ok   = ({1'b0, card_idx} < c_num_acct);
  assign w_dest_ok   = ({1'b0, dest_idx} < c_num_acct);
  assign w_sess_bal  = bal_q[sess_q];
  // Out-of-range destinations never reach the overflow check, so reading 0
  // keeps the index in range without changing the result.
  assign w_dest_bal  = w_dest_ok ? bal_q[dest_idx] : '0;
  // The extra MSB of these sums is the overflow flag.
  assign w_dep_sum   = {1'b0, w_sess_bal} + {1'b0, amount};
  assign w_xfer_sum  = {1'b0, w_dest_bal} + {1'b0, amount};
  assign w_tries_inc = tries_q + 1'b1;
  assign w_exec_bal  = (op_q == c_op_deposit) ? (w_sess_bal + amt_q)
                                              : (w_sess_bal - amt_q);
  assign w_timed     = (state_q == S_PIN) || (state_q == S_HOME) ||
                       (state_q == S_AMT) || (state_q == S_CONFIRM);
  assign w_timeout   = w_timed && (timer_q == c_tmr_max);

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    sess_d     = sess_q;
    tries_d    = tries_q;
    op_d       = op_q;
    amt_d      = amt_q;
    dest_d     = dest_q;
    rcpt_d     = rcpt_q;
    lock_d     = lock_q;
    for (int i = 0; i < NUM_ACCTS; i++) bal_d[i] = bal_q[i];
    balance_d  = balance_q;
    err_d      = err_q;
    locked_d   = locked_q;
    done_d     = 1'b0;
    errv_d     = 1'b0;
    w_consumed = 1'b0;

    if (w_timeout) begin
      // Timeout wins over any strobe arriving in the same cycle.
      err_d   = c_err_timeout;
      errv_d  = 1'b1;
      state_d = S_EJECT;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (card_in) begin
            if (!w_card_ok) begin
              err_d   = c_err_idx;
              errv_d  = 1'b1;
              state_d = S_EJECT;
            end else if (lock_q[card_idx]) begin
              sess_d   = card_idx;
              err_d    = c_err_locked;
              errv_d   = 1'b1;
              locked_d = 1'b1;
              state_d  = S_EJECT;
            end else begin
              sess_d   = card_idx;
              tries_d  = '0;
              err_d    = c_err_none;
              locked_d = 1'b0;
              state_d  = S_PIN;
            end
          end
        end

        S_PIN: begin
          if (pin_valid) begin
            w_consumed = 1'b1;
            if (pin == c_pin) begin
              tries_d   = '0;
              balance_d = w_sess_bal;
              state_d   = S_HOME;
            end else begin
              tries_d = w_tries_inc;
              err_d   = c_err_pin;
              errv_d  = 1'b1;
              if (w_tries_inc == c_max_try) begin
                lock_d[sess_q] = 1'b1;
                locked_d       = 1'b1;
                state_d        = S_EJECT;
              end
            end
          end
        end

        S_HOME: begin
          if (op_valid) begin
            w_consumed = 1'b1;
            case (opcode)
              c_op_eject:   state_d = S_EJECT;
              c_op_balance: begin
                balance_d = w_sess_bal;
                state_d   = S_BAL;
              end
              c_op_withdraw, c_op_deposit, c_op_transfer: begin
                op_d    = opcode;
                state_d = S_AMT;
              end
              default: begin
                err_d  = c_err_opcode;
                errv_d = 1'b1;
              end
            endcase
          end
        end

        S_BAL: state_d = S_HOME;

        S_AMT: begin
          if (amt_valid) begin
            w_consumed = 1'b1;
            amt_d      = amount;
            dest_d     = dest_idx;
            state_d    = S_HOME;
            errv_d     = 1'b1;
            if (amount == '0) begin
              err_d = c_err_zero;
            end else if ((op_q == c_op_transfer) &&
                         (!w_dest_ok || (dest_idx == sess_q))) begin
              err_d = c_err_idx;
            end else if (((op_q == c_op_withdraw) || (op_q == c_op_transfer)) &&
                         (amount > w_sess_bal)) begin
              err_d = c_err_funds;
            end else if ((op_q == c_op_deposit) && w_dep_sum[AMT_W]) begin
              err_d = c_err_ovf;
            end else if ((op_q == c_op_transfer) && w_xfer_sum[AMT_W]) begin
              err_d = c_err_ovf;
            end else begin
              errv_d  = 1'b0;
              state_d = S_CONFIRM;
            end
          end
        end

        S_CONFIRM: begin
          if (confirm_valid) begin
            w_consumed = 1'b1;
            if (confirm) begin
              rcpt_d  = receipt_req;
              state_d = S_EXEC;
            end else begin
              state_d = S_HOME;
            end
          end
        end

        S_EXEC: begin
          // Transfer never targets the session account, so both writes
          // below land on distinct entries.
          bal_d[sess_q] = w_exec_bal;
          if (op_q == c_op_transfer) begin
            bal_d[dest_q] = bal_q[dest_q] + amt_q;
          end
          balance_d = w_exec_bal;
          done_d    = 1'b1;
          state_d   = rcpt_q ? S_RECEIPT : S_HOME;
        end

        S_RECEIPT: state_d = S_HOME;

        S_EJECT:   state_d = S_IDLE;

        default:   state_d = S_IDLE;
      endcase
    end

    // Receipt and eject pulses coincide with their state being visible.
    receipt_d = (state_d == S_RECEIPT) && (state_q != S_RECEIPT);
    eject_d   = (state_d == S_EJECT) && (state_q != S_EJECT);

    if (!w_timed || (state_d != state_q) || w_consumed) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      sess_q    <= '0;
      tries_q   <= '0;
      timer_q   <= '0;
      op_q      <= '0;
      amt_q     <= '0;
      dest_q    <= '0;
      rcpt_q    <= 1'b0;
      lock_q    <= '0;
      for (int i = 0; i < NUM_ACCTS; i++) bal_q[i] <= c_init_bal;
      balance_q <= '0;
      done_q    <= 1'b0;
      receipt_q <= 1'b0;
      eject_q   <= 1'b0;
      errv_q    <= 1'b0;
      err_q     <= '0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sess_q    <= sess_d;
      tries_q   <= tries_d;
      timer_q   <= timer_d;
      op_q      <= op_d;
      amt_q     <= amt_d;
      dest_q    <= dest_d;
      rcpt_q    <= rcpt_d;
      lock_q    <= lock_d;
      for (int i = 0; i < NUM_ACCTS; i++) bal_q[i] <= bal_d[i];
      balance_q <= balance_d;
      done_q    <= done_d;
      receipt_q <= receipt_d;
      eject_q   <= eject_d;
      errv_q    <= errv_d;
      err_q     <= err_d;
      locked_q  <= locked_d;
    end
  end

  assign state_o    = state_q;
  assign balance_o  = balance_q;
  assign done       = done_q;
  assign receipt    = receipt_q;
  assign card_eject = eject_q;
  assign err_valid  = errv_q;
  assign err        = err_q;
  assign locked     = locked_q;

endmodule
`default_nettype wire
